// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and data (D) requesters.
// Defining MEM_ARB_TIMEOUT_EN adds a BUSY-cycle watchdog that aborts stalled accesses.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int D_BURST_MAX    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(D_BURST_MAX);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic [31:0]       rdata_in;
  logic              grant_i, grant_d;
  logic              timeout_hit;
  logic              abort_q;

  // D wins contention until it has taken STREAK_MAX grants in a row over a waiting fetch.
  assign grant_d = d_req && (!i_req || (streak_q != STREAK_MAX));
  assign grant_i = i_req && !grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int             TCW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] tcnt_q;
  logic           err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_BUSY) tcnt_q <= tcnt_q + 1'b1;
      else                    tcnt_q <= '0;
      if (state_q == ST_BUSY) err_q <= timeout_hit;
    end
  end

  // Abort at the end of the TIMEOUT_CYCLES-th BUSY cycle; a late mem_ready still wins.
  assign timeout_hit = (state_q == ST_BUSY) && !mem_ready && (tcnt_q == T_LAST);
  assign abort_q     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign abort_q     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_req || d_req)             state_d = ST_BUSY;
      ST_BUSY: if (mem_ready || timeout_hit)   state_d = ST_RESP;
      ST_RESP:                                 state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == ST_BUSY);
    i_ready = (state_q == ST_RESP) && (owner_q == OWN_I);
    d_ready = (state_q == ST_RESP) && (owner_q == OWN_D);
    err     = (state_q == ST_RESP) && abort_q;
  end

  always_comb begin
    owner_d   = owner_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    rdata_in  = mem_ready ? mem_rdata : 32'h0;
    if (state_q == ST_IDLE) begin
      if (grant_d) begin
        owner_d = OWN_D;
        addr_d  = d_addr;
        we_d    = d_we;
        wdata_d = d_wdata;
        wstrb_d = d_we ? d_wstrb : 4'h0;
        if (!i_req)                       streak_d = 4'd0;
        else if (streak_q != STREAK_MAX)  streak_d = streak_q + 4'd1;
      end else if (grant_i) begin
        owner_d  = OWN_I;
        addr_d   = i_addr;
        we_d     = 1'b0;
        wdata_d  = 32'h0;
        wstrb_d  = 4'h0;
        streak_d = 4'd0;
      end
    end else if ((state_q == ST_BUSY) && (mem_ready || timeout_hit)) begin
      if (owner_q == OWN_I)
        i_rdata_d = rdata_in;
      else if ((owner_q == OWN_D) && (!we_q || timeout_hit))
        d_rdata_d = rdata_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_NONE;
      streak_q  <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
